// File: rtl/prbs_seq_pkg.sv
// prbs_seq_pkg: shared state enum, error codes and ordered-set length for the PRBS11 sequencer
package prbs_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRBS, S_DRAIN, S_TS, S_DONE, S_ERROR} state_e;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SKEW    = 2'b10;
  localparam int OS_BITS = 448;
endpackage

// File: rtl/prbs_os_counter.sv
// prbs_os_counter: saturating ordered-set counter with clear, increment and threshold flags
module prbs_os_counter #(
  parameter int CNT_W  = 10,
  parameter int OS_MIN = 4,
  parameter int OS_MAX = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_min_o,
  output logic             at_max_o
);
  logic [CNT_W-1:0] count_q, count_d;
  assign at_min_o = count_q >= CNT_W'(OS_MIN);
  assign at_max_o = count_q >= CNT_W'(OS_MAX);
  assign count_d  = clr_i ? '0 : (inc_i && !at_max_o) ? count_q + 1'b1 : count_q;
  assign count_o  = count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/prbs11_seq_ctrl.sv
// prbs11_seq_ctrl: Gen4 PRBS11 ordered-set phase sequencer for lanes 0/1 with exit-on-boundary and timeout.
// Define PRBS_SKEW_CHECK_EN to flag lane skew when the two lanes' ordered-set pulses disagree.
module prbs11_seq_ctrl
  import prbs_seq_pkg::*;
#(
  parameter int OS_MIN = 4,
  parameter int OS_MAX = 1023,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             os_sent_l0,
  input  logic             os_sent_l1,
  input  logic             rx_locked,
  input  logic             ts_done,
  output logic             prbs_en_l0,
  output logic             prbs_en_l1,
  output logic             ts_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] os_count
);
  state_e     state_q, state_d;
  logic [1:0] err_code_q, err_code_d, code_new;
  logic       start_q, prbs_en_q, ts_en_q, busy_q, done_q, err_q;
  logic       active, rise, skew, timeout, at_min, at_max;
  assign active = state_q == S_PRBS || state_q == S_DRAIN;
  assign rise   = start && !start_q;
`ifdef PRBS_SKEW_CHECK_EN
  assign skew = active && (os_sent_l0 != os_sent_l1);
`else
  logic unused_l1;
  assign unused_l1 = os_sent_l1;
  assign skew      = 1'b0;
`endif
  // Timeout fires on the pulse that brings the count up to OS_MAX (or finds it already there).
  assign timeout = os_sent_l0 && (at_max || os_count == CNT_W'(OS_MAX - 1));
  prbs_os_counter #(.CNT_W(CNT_W), .OS_MIN(OS_MIN), .OS_MAX(OS_MAX)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_d == S_IDLE),
    .inc_i    (active && os_sent_l0),
    .count_o  (os_count),
    .at_min_o (at_min),
    .at_max_o (at_max)
  );
  always_comb begin
    state_d  = state_q;
    code_new = ERR_NONE;
    case (state_q)
      S_IDLE:  state_d = rise ? S_PRBS : S_IDLE;
      S_PRBS: begin
        if (skew) begin
          state_d  = S_ERROR;
          code_new = ERR_SKEW;
        end else if (at_min && rx_locked) state_d = S_DRAIN;
        else if (timeout) begin
          state_d  = S_ERROR;
          code_new = ERR_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (skew) begin
          state_d  = S_ERROR;
          code_new = ERR_SKEW;
        end else if (os_sent_l0) state_d = S_TS;
      end
      S_TS:    state_d = ts_done ? S_DONE : S_TS;
      S_DONE:  state_d = start ? S_DONE : S_IDLE;
      S_ERROR: state_d = start ? S_ERROR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    err_code_d = state_d != S_ERROR ? ERR_NONE : state_q == S_ERROR ? err_code_q : code_new;
  end
  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      start_q    <= 1'b0;
      prbs_en_q  <= 1'b0;
      ts_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      start_q    <= start;
      prbs_en_q  <= state_d == S_PRBS || state_d == S_DRAIN;
      ts_en_q    <= state_d == S_TS;
      busy_q     <= state_d == S_PRBS || state_d == S_DRAIN || state_d == S_TS;
      done_q     <= state_d == S_DONE;
      err_q      <= state_d == S_ERROR;
    end
  assign prbs_en_l0 = prbs_en_q;
  assign prbs_en_l1 = prbs_en_q;
  assign ts_en      = ts_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
endmodule

// File: tb/tb_prbs11_seq_ctrl.sv
// tb_prbs11_seq_ctrl: directed self-checking bench for the PRBS11 sequencer (OS_MIN=4, OS_MAX=8).
module tb_prbs11_seq_ctrl;
  localparam int CNT_W = 10;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic os_sent_l0 = 1'b0, os_sent_l1 = 1'b0, rx_locked = 1'b0, ts_done = 1'b0;
  logic prbs_en_l0, prbs_en_l1, ts_en, busy, done, err;
  logic [1:0] err_code;
  logic [CNT_W-1:0] os_count;
  logic [7:0] outs;
  int checks = 0, errors = 0;
  prbs11_seq_ctrl #(.OS_MIN(4), .OS_MAX(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .os_sent_l0(os_sent_l0), .os_sent_l1(os_sent_l1), .rx_locked(rx_locked), .ts_done(ts_done),
    .prbs_en_l0(prbs_en_l0), .prbs_en_l1(prbs_en_l1), .ts_en(ts_en), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .os_count(os_count)
  );
  always #5 clk = ~clk;
  // {en_l0, en_l1, ts_en, busy, done, err, err_code}
  assign outs = {prbs_en_l0, prbs_en_l1, ts_en, busy, done, err, err_code};
  localparam logic [7:0] O_IDLE = 8'h00, O_PRBS = 8'hD0, O_TS = 8'h30, O_DONE = 8'h08;
  localparam logic [7:0] O_TMO = 8'h05, O_SKEW = 8'h06;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic os_pulse(input int gap);
    repeat (gap) tick();
    os_sent_l0 = 1'b1;
    os_sent_l1 = 1'b1;
    tick();
    os_sent_l0 = 1'b0;
    os_sent_l1 = 1'b0;
  endtask
  task automatic restart();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask
  initial begin
    #1;
    check("reset_outs", 32'(outs), 32'(O_IDLE));
    check("reset_cnt", 32'(os_count), 0);
    tick();
    reset = 1'b0;
    tick();
    // Normal completion with 448-cycle ordered sets
    rx_locked = 1'b1;
    start = 1'b1;
    tick();
    check("start_en", 32'(outs), 32'(O_PRBS));
    check("start_cnt", 32'(os_count), 0);
    for (int k = 1; k <= 4; k++) os_pulse(447);
    check("cnt4", 32'(os_count), 4);
    repeat (447) tick();
    check("drain_en", 32'(outs), 32'(O_PRBS));
    os_sent_l0 = 1'b1;
    os_sent_l1 = 1'b1;
    rx_locked  = 1'b0;
    tick();
    os_sent_l0 = 1'b0;
    os_sent_l1 = 1'b0;
    check("ts_entry", 32'(outs), 32'(O_TS));
    check("ts_cnt", 32'(os_count), 5);
    tick();
    check("ts_hold", 32'(outs), 32'(O_TS));
    ts_done = 1'b1;
    tick();
    ts_done = 1'b0;
    check("done", 32'(outs), 32'(O_DONE));
    repeat (3) tick();
    check("done_hold", 32'(outs), 32'(O_DONE));
    start = 1'b0;
    tick();
    check("done_idle", 32'(outs), 32'(O_IDLE));
    check("done_idle_cnt", 32'(os_count), 0);
    // Timeout: no lock, 8th set hits OS_MAX
    start = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) os_pulse(447);
    check("tmo_pre", 32'(outs), 32'(O_PRBS));
    check("tmo_cnt7", 32'(os_count), 7);
    os_pulse(447);
    check("tmo_err", 32'(outs), 32'(O_TMO));
    check("tmo_cnt8", 32'(os_count), 8);
    repeat (2) tick();
    check("tmo_hold", 32'(outs), 32'(O_TMO));
    start = 1'b0;
    tick();
    check("tmo_idle", 32'(outs), 32'(O_IDLE));
    // Lane-1 pulse one cycle late on the 2nd set
    start = 1'b1;
    tick();
    os_pulse(3);
    repeat (3) tick();
    os_sent_l0 = 1'b1;
    tick();
    os_sent_l0 = 1'b0;
`ifdef PRBS_SKEW_CHECK_EN
    check("skew_err", 32'(outs), 32'(O_SKEW));
    os_sent_l1 = 1'b1;
    tick();
    os_sent_l1 = 1'b0;
    check("skew_hold", 32'(outs), 32'(O_SKEW));
    start = 1'b0;
    tick();
    check("skew_idle", 32'(outs), 32'(O_IDLE));
`else
    check("noskew_en", 32'(outs), 32'(O_PRBS));
    check("noskew_cnt", 32'(os_count), 2);
    os_sent_l1 = 1'b1;
    tick();
    os_sent_l1 = 1'b0;
    rx_locked = 1'b1;
    os_pulse(3);
    os_pulse(3);
    os_pulse(3);
    check("noskew_ts", 32'(outs), 32'(O_TS));
    check("noskew_cnt5", 32'(os_count), 5);
    ts_done = 1'b1;
    tick();
    ts_done = 1'b0;
    check("noskew_done", 32'(outs), 32'(O_DONE));
    start = 1'b0;
    tick();
`endif
    // Abort in PRBS, DRAIN and TS
    rx_locked = 1'b0;
    restart();
    os_pulse(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_prbs", 32'(outs), 32'(O_IDLE));
    check("abort_prbs_cnt", 32'(os_count), 0);
    rx_locked = 1'b1;
    restart();
    check("restart_cnt", 32'(os_count), 0);
    check("restart_en", 32'(outs), 32'(O_PRBS));
    for (int k = 1; k <= 4; k++) os_pulse(2);
    tick();
    check("drain_pre_abort", 32'(outs), 32'(O_PRBS));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_drain", 32'(outs), 32'(O_IDLE));
    check("abort_drain_cnt", 32'(os_count), 0);
    restart();
    for (int k = 1; k <= 5; k++) os_pulse(2);
    check("ts_pre_abort", 32'(outs), 32'(O_TS));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ts", 32'(outs), 32'(O_IDLE));
    check("abort_ts_cnt", 32'(os_count), 0);
    // Asynchronous reset mid-PRBS
    restart();
    os_pulse(2);
    os_pulse(2);
    check("pre_rst_cnt", 32'(os_count), 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs), 32'(O_IDLE));
    check("async_rst_cnt", 32'(os_count), 0);
    #1 reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
